// File: rtl/fetch_unit.sv
// Program-counter and fetch sequencer for the 9-bit single-cycle core, with a
// software-loadable branch-target LUT. Optional counters under FETCH_PERF_EN.
module fetch_unit #(
    parameter int PC_W      = 10,
    parameter int LUT_IDX_W = 5
) (
    input  logic                 CLK,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [PC_W-1:0]      start_addr,
    input  logic                 halt,
    input  logic                 branch_en,
    input  logic [LUT_IDX_W-1:0] branch_idx,
    input  logic                 lut_we,
    input  logic [LUT_IDX_W-1:0] lut_waddr,
    input  logic [PC_W-1:0]      lut_wdata,
    output logic [PC_W-1:0]      prog_ctr,
    output logic                 fetch_valid,
    output logic                 done
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]          instr_count,
    output logic [15:0]          taken_count
`endif
);

    localparam int LUT_DEPTH = 1 << LUT_IDX_W;
    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [PC_W-1:0] r_prog_ctr;
    logic [PC_W-1:0] w_next_pc;
    logic [PC_W-1:0] r_lut [LUT_DEPTH];
    logic [PC_W-1:0] w_branch_target;
    logic            w_branch_taken;

    // Combinational read sees the pre-write entry, giving read-before-write.
    assign w_branch_target = r_lut[branch_idx];

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_prog_ctr <= '0;
        end else begin
            r_state    <= w_next_state;
            r_prog_ctr <= w_next_pc;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_next_pc      = r_prog_ctr;
        w_branch_taken = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_pc    = start_addr;
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (start) begin
                    w_next_pc = start_addr;
                end else if (halt) begin
                    w_next_state = ST_HALTED;
                end else if (branch_en) begin
                    w_next_pc      = w_branch_target;
                    w_branch_taken = 1'b1;
                end else begin
                    w_next_pc = r_prog_ctr + PC_ONE;
                end
            end
            ST_HALTED: begin
                if (start) begin
                    w_next_pc    = start_addr;
                    w_next_state = ST_RUN;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_pc    = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                r_lut[i] <= '0;
            end
        end else if (lut_we) begin
            r_lut[lut_waddr] <= lut_wdata;
        end
    end

    assign prog_ctr    = r_prog_ctr;
    assign fetch_valid = (r_state == ST_RUN);
    assign done        = (r_state == ST_HALTED);

`ifdef FETCH_PERF_EN
    logic [15:0] r_instr_count;
    logic [15:0] r_taken_count;

    // Both counters saturate; start clears them regardless of state.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_instr_count <= '0;
            r_taken_count <= '0;
        end else if (start) begin
            r_instr_count <= '0;
            r_taken_count <= '0;
        end else begin
            if ((r_state == ST_RUN) && (r_instr_count != 16'hFFFF)) begin
                r_instr_count <= r_instr_count + 16'd1;
            end
            if (w_branch_taken && (r_taken_count != 16'hFFFF)) begin
                r_taken_count <= r_taken_count + 16'd1;
            end
        end
    end

    assign instr_count = r_instr_count;
    assign taken_count = r_taken_count;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written
// corner sequences, and randomized traffic against a behavioural model.
module tb_fetch_unit;

    logic       CLK;
    logic       reset_n;
    logic       start;
    logic [9:0] startAddr;
    logic       halt;
    logic       branchEn;
    logic [4:0] branchIdx;
    logic       lutWe;
    logic [4:0] lutWaddr;
    logic [9:0] lutWdata;
    logic [9:0] progCtr;
    logic       fetchValid;
    logic       doneOut;
`ifdef FETCH_PERF_EN
    logic [15:0] instrCount;
    logic [15:0] takenCount;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       start;
        logic [9:0] startAddr;
        logic       halt;
        logic       branchEn;
        logic [4:0] branchIdx;
        logic       lutWe;
        logic [4:0] lutWaddr;
        logic [9:0] lutWdata;
        logic [9:0] expPc;
        logic       expValid;
        logic       expDone;
    } vec_t;

    vec_t vectors[20];

    // Behavioural model: run/halt flags, PC as an integer, LUT as an int array.
    bit mRunning;
    bit mHalted;
    int mPc;
    int mLut[32];
    int mInstr;
    int mTaken;

    fetch_unit #(.PC_W(10), .LUT_IDX_W(5)) dut (
        .CLK(CLK),
        .reset_n(reset_n),
        .start(start),
        .start_addr(startAddr),
        .halt(halt),
        .branch_en(branchEn),
        .branch_idx(branchIdx),
        .lut_we(lutWe),
        .lut_waddr(lutWaddr),
        .lut_wdata(lutWdata),
        .prog_ctr(progCtr),
        .fetch_valid(fetchValid),
        .done(doneOut)
`ifdef FETCH_PERF_EN
        ,
        .instr_count(instrCount),
        .taken_count(takenCount)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic vec_t mkVec(logic s, logic [9:0] sa, logic h, logic b, logic [4:0] bi,
                                   logic we, logic [4:0] wa, logic [9:0] wd,
                                   logic [9:0] ePc, logic eV, logic eD);
        vec_t v;
        v.start = s; v.startAddr = sa; v.halt = h; v.branchEn = b; v.branchIdx = bi;
        v.lutWe = we; v.lutWaddr = wa; v.lutWdata = wd;
        v.expPc = ePc; v.expValid = eV; v.expDone = eD;
        return v;
    endfunction

    // Drive one cycle's inputs on the falling edge, then step past the rising edge.
    task automatic applyStimulus(input vec_t v);
        @(negedge CLK);
        start = v.start; startAddr = v.startAddr; halt = v.halt;
        branchEn = v.branchEn; branchIdx = v.branchIdx;
        lutWe = v.lutWe; lutWaddr = v.lutWaddr; lutWdata = v.lutWdata;
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [9:0] ePc, input logic eV, input logic eD);
        checks++;
        if (progCtr !== ePc) begin
            errors++;
            $display("[TB] FAIL %s prog_ctr: got %h expected %h", name, progCtr, ePc);
        end
        checks++;
        if (fetchValid !== eV) begin
            errors++;
            $display("[TB] FAIL %s fetch_valid: got %b expected %b", name, fetchValid, eV);
        end
        checks++;
        if (doneOut !== eD) begin
            errors++;
            $display("[TB] FAIL %s done: got %b expected %b", name, doneOut, eD);
        end
    endtask

`ifdef FETCH_PERF_EN
    task automatic checkPerf(input string name, input int eInstr, input int eTaken);
        checks++;
        if (instrCount !== 16'(eInstr)) begin
            errors++;
            $display("[TB] FAIL %s instr_count: got %0d expected %0d", name, instrCount, eInstr);
        end
        checks++;
        if (takenCount !== 16'(eTaken)) begin
            errors++;
            $display("[TB] FAIL %s taken_count: got %0d expected %0d", name, takenCount, eTaken);
        end
    endtask
`endif

    task automatic modelReset();
        mRunning = 0; mHalted = 0; mPc = 0; mInstr = 0; mTaken = 0;
        for (int i = 0; i < 32; i++) mLut[i] = 0;
    endtask

    // Applies one rising edge to the model from the inputs currently driven.
    task automatic modelStep();
        bit wasRunning;
        bit tookBranch;
        wasRunning = mRunning;
        tookBranch = 0;
        if (start) begin
            mPc = int'(startAddr); mRunning = 1; mHalted = 0;
        end else if (mRunning) begin
            if (halt) begin
                mRunning = 0; mHalted = 1;
            end else if (branchEn) begin
                mPc = mLut[branchIdx]; tookBranch = 1;
            end else begin
                mPc = (mPc + 1) % 1024;
            end
        end
        if (lutWe) mLut[lutWaddr] = int'(lutWdata);
        if (start) begin
            mInstr = 0; mTaken = 0;
        end else begin
            if (wasRunning && mInstr < 65535) mInstr++;
            if (tookBranch && mTaken < 65535) mTaken++;
        end
    endtask

    task automatic idleInputs();
        start = 0; startAddr = '0; halt = 0; branchEn = 0; branchIdx = '0;
        lutWe = 0; lutWaddr = '0; lutWdata = '0;
    endtask

    initial begin
        vec_t v;
        idleInputs();
        reset_n = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("reset", 10'h000, 1'b0, 1'b0);
`ifdef FETCH_PERF_EN
        checkPerf("reset", 0, 0);
`endif
        @(negedge CLK);
        reset_n = 1'b1;

        // IDLE ignores halt and branch requests.
        applyStimulus(mkVec(0, 10'h000, 1, 1, 5'd7, 0, 5'd0, 10'h000, 10'h000, 0, 0));
        checkOutput("idle_ignore", 10'h000, 1'b0, 1'b0);

        vectors[0]  = mkVec(1, 10'h004, 0, 0, 5'd0, 0, 5'd0, 10'h000, 10'h004, 1, 0);
        vectors[1]  = mkVec(0, 10'h000, 0, 0, 5'd0, 0, 5'd0, 10'h000, 10'h005, 1, 0);
        vectors[2]  = mkVec(0, 10'h000, 0, 0, 5'd0, 0, 5'd0, 10'h000, 10'h006, 1, 0);
        vectors[3]  = mkVec(0, 10'h000, 0, 0, 5'd0, 0, 5'd0, 10'h000, 10'h007, 1, 0);
        vectors[4]  = mkVec(0, 10'h000, 0, 0, 5'd0, 1, 5'd3, 10'h120, 10'h008, 1, 0);
        vectors[5]  = mkVec(0, 10'h000, 0, 0, 5'd0, 1, 5'd2, 10'h080, 10'h009, 1, 0);
        vectors[6]  = mkVec(1, 10'h010, 0, 0, 5'd0, 0, 5'd0, 10'h000, 10'h010, 1, 0);
        vectors[7]  = mkVec(0, 10'h000, 0, 1, 5'd3, 0, 5'd0, 10'h000, 10'h120, 1, 0);
        vectors[8]  = mkVec(0, 10'h000, 0, 0, 5'd0, 0, 5'd0, 10'h000, 10'h121, 1, 0);
        vectors[9]  = mkVec(0, 10'h000, 0, 1, 5'd2, 1, 5'd2, 10'h200, 10'h080, 1, 0);
        vectors[10] = mkVec(0, 10'h000, 0, 0, 5'd0, 0, 5'd0, 10'h000, 10'h081, 1, 0);
        vectors[11] = mkVec(0, 10'h000, 0, 1, 5'd2, 0, 5'd0, 10'h000, 10'h200, 1, 0);
        vectors[12] = mkVec(1, 10'h3FF, 0, 0, 5'd0, 0, 5'd0, 10'h000, 10'h3FF, 1, 0);
        vectors[13] = mkVec(0, 10'h000, 0, 0, 5'd0, 0, 5'd0, 10'h000, 10'h000, 1, 0);
        vectors[14] = mkVec(1, 10'h050, 0, 0, 5'd0, 0, 5'd0, 10'h000, 10'h050, 1, 0);
        vectors[15] = mkVec(0, 10'h000, 1, 1, 5'd3, 0, 5'd0, 10'h000, 10'h050, 0, 1);
        vectors[16] = mkVec(0, 10'h000, 1, 1, 5'd3, 0, 5'd0, 10'h000, 10'h050, 0, 1);
        vectors[17] = mkVec(1, 10'h000, 0, 0, 5'd0, 0, 5'd0, 10'h000, 10'h000, 1, 0);
        vectors[18] = mkVec(0, 10'h000, 0, 0, 5'd0, 0, 5'd0, 10'h000, 10'h001, 1, 0);
        vectors[19] = mkVec(1, 10'h100, 1, 1, 5'd3, 0, 5'd0, 10'h000, 10'h100, 1, 0);

        for (int i = 0; i < 20; i++) begin
            applyStimulus(vectors[i]);
            checkOutput($sformatf("vec%0d", i), vectors[i].expPc, vectors[i].expValid, vectors[i].expDone);
        end

        // Asynchronous reset mid-RUN must clear outputs before the next rising edge.
        applyStimulus(mkVec(1, 10'h033, 0, 0, 5'd0, 0, 5'd0, 10'h000, 10'h000, 0, 0));
        checkOutput("pre_async", 10'h033, 1'b1, 1'b0);
        @(negedge CLK);
        idleInputs();
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async_reset", 10'h000, 1'b0, 1'b0);
`ifdef FETCH_PERF_EN
        checkPerf("async_reset", 0, 0);
`endif
        @(negedge CLK);
        reset_n = 1'b1;

        // LUT entries were cleared by reset, so lut[3] now targets address 0.
        applyStimulus(mkVec(1, 10'h040, 0, 0, 5'd0, 0, 5'd0, 10'h000, 10'h000, 0, 0));
        checkOutput("lut_cleared_start", 10'h040, 1'b1, 1'b0);
        applyStimulus(mkVec(0, 10'h000, 0, 1, 5'd3, 0, 5'd0, 10'h000, 10'h000, 0, 0));
        checkOutput("lut_cleared_branch", 10'h000, 1'b1, 1'b0);

        // Randomized traffic against the model, starting from a fresh reset.
        @(negedge CLK);
        idleInputs();
        reset_n = 1'b0;
        modelReset();
        @(negedge CLK);
        reset_n = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            @(negedge CLK);
            start     = ($urandom_range(0, 15) == 0);
            startAddr = ($urandom_range(0, 3) == 0) ? 10'(10'h3FC + $urandom_range(0, 3))
                                                    : 10'($urandom_range(0, 1023));
            halt      = ($urandom_range(0, 19) == 0);
            branchEn  = ($urandom_range(0, 3) == 0);
            branchIdx = 5'($urandom_range(0, 31));
            lutWe     = ($urandom_range(0, 3) == 0);
            lutWaddr  = 5'($urandom_range(0, 31));
            lutWdata  = 10'($urandom_range(0, 1023));
            @(posedge CLK);
            #1;
            modelStep();
            checkOutput($sformatf("rand%0d", n), 10'(mPc), mRunning, mHalted);
`ifdef FETCH_PERF_EN
            checkPerf($sformatf("rand%0d", n), mInstr, mTaken);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter and fetch sequencer for the 9-bit single-cycle core.
- Sits directly downstream of the control decoder and consumes its branch_en output.
- Drives the instruction ROM address each cycle.
- Resolves taken branches through an internal, software-loadable branch-target lookup table.
- Provides the start/done handshake to the testbench or top level.

Parameters:
- PC_W, 10, width of prog_ctr and of each LUT entry (instruction ROM depth 2^PC_W)
- LUT_IDX_W, 5, width of the branch-target index; the LUT has 2^LUT_IDX_W entries

Ports:
- CLK  input  1  core clock, all state updates on rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse: load start_addr and begin fetching
- start_addr  input  PC_W  first instruction address for this run
- halt  input  1  decoded halt instruction at current prog_ctr
- branch_en  input  1  taken-branch request from control decoder
- branch_idx  input  LUT_IDX_W  LUT index taken from the current instruction's low bits
- lut_we  input  1  LUT write enable
- lut_waddr  input  LUT_IDX_W  LUT write address
- lut_wdata  input  PC_W  LUT write data (absolute target address)
- prog_ctr  output  PC_W  current instruction address to instruction ROM
- fetch_valid  output  1  high while prog_ctr addresses a live instruction
- done  output  1  high from the cycle after halt until the next start

Behaviour:
- Reset (async, reset_n low):
  - state=IDLE; prog_ctr=0; fetch_valid=0; done=0.
  - All LUT entries=0.
  - Reset mid-RUN aborts immediately; no partial update survives.
- States: IDLE, RUN, HALTED. fetch_valid=1 only in RUN. done=1 only in HALTED.
- IDLE:
  - start=1 -> prog_ctr<=start_addr, state<=RUN.
  - All other inputs except the LUT write port are ignored.
- RUN, per cycle, priority highest first:
  1. start=1 -> prog_ctr<=start_addr, stay RUN (restart).
  2. halt=1 -> state<=HALTED, prog_ctr holds, done<=1.
  3. branch_en=1 -> prog_ctr<=lut[branch_idx].
  4. Otherwise prog_ctr<=prog_ctr+1, modulo 2^PC_W (all-ones wraps to 0, no flag).
- Simultaneous halt and branch_en: halt wins; the branch is discarded.
- HALTED:
  - prog_ctr and done hold.
  - halt and branch_en are ignored.
  - start=1 -> prog_ctr<=start_addr, done<=0, state<=RUN.
- Latency:
  - Instruction ROM and decoder are combinational, so halt/branch_en/branch_idx describe prog_ctr in the same cycle.
  - The next-PC decision is visible on prog_ctr one cycle later.
  - done rises one cycle after halt is sampled.
- LUT:
  - Synchronous write when lut_we=1, in any state, including during RUN.
  - Read is combinational.
  - Same-cycle write and branch to the same index: the branch uses the old entry (read-before-write); the new value applies from the next cycle.
- Widths: branch targets are absolute. No sign extension or relative offset arithmetic.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, adds outputs instr_count[15:0] and taken_count[15:0].
  - Both reset to 0 and are cleared on start.
  - instr_count increments on every RUN cycle, including the halt cycle.
  - taken_count increments on every taken branch actually applied (not on a branch suppressed by start or halt).
  - Both saturate at 16'hFFFF.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset then start with start_addr=10'h004 -> next cycle prog_ctr=4, fetch_valid=1; following cycles 5, 6, 7; done=0.
- Write lut[3]=10'h120; in RUN at prog_ctr=10'h010 assert branch_en=1, branch_idx=3 -> next prog_ctr=10'h120; then 10'h121.
- At prog_ctr=10'h3FF with no branch/halt -> next prog_ctr=0, state still RUN.
- At prog_ctr=10'h050 assert halt and branch_en together -> prog_ctr stays 10'h050, done=1 next cycle, fetch_valid=0. Then start with start_addr=0 -> done=0, prog_ctr=0, RUN.
- Same cycle: lut_we=1, lut_waddr=2, lut_wdata=10'h200 with branch_en=1, branch_idx=2, old lut[2]=10'h080 -> prog_ctr=10'h080; a later branch via idx 2 -> 10'h200.
- Drop reset_n asynchronously mid-RUN at prog_ctr=10'h033 -> prog_ctr=0, fetch_valid=0, done=0 before the next clock edge. With FETCH_PERF_EN defined, both counters read 0.
